ieee_to_fixed_converter: RTL and testbench

// - Sequential inverse of the fixed->IEEE converter: accepts a packed {sign,exp[7:0],montissa} word,

---
 rtl/ieee_to_fixed_converter.sv | 145 ++++++++++++++
 tb/tb_ieee_to_fixed_converter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_to_fixed_converter.sv
// IEEE-style {sign, exp[7:0], montissa} to sign-magnitude fixed point (INT_LEN.FRA_LEN), valid/ready in and out.
// Default: iterative shifter, 1 bit per cycle; define IEEE_TO_FIXED_FAST_SHIFT_EN for a single-cycle barrel shift at load.
module ieee_to_fixed_converter #(
  parameter int INT_LEN      = 16,
  parameter int FRA_LEN      = 16,
  parameter int MONTISSA_LEN = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MONTISSA_LEN+8:0] ieee_val,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [INT_LEN-1:0]      o_integer,
  output logic [FRA_LEN-1:0]      o_fraction,
  output logic                    sign_flag,
  output logic                    ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int W_LEN   = INT_LEN + FRA_LEN + MONTISSA_LEN;
  localparam int MAX_RSH = FRA_LEN + MONTISSA_LEN;
  localparam int MAX_SH  = (INT_LEN - 1 > MAX_RSH) ? INT_LEN - 1 : MAX_RSH;
  localparam int CNT_W   = $clog2(MAX_SH + 1);

  localparam logic signed [8:0]  E_OVF   = 9'(INT_LEN);
  localparam logic signed [8:0]  E_MIN   = -9'(MAX_RSH);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [W_LEN-1:0]   W_SAT   = {{(INT_LEN + FRA_LEN){1'b1}}, {MONTISSA_LEN{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W_LEN-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               sign_q, sign_d;
  logic               ovf_q, ovf_d;

  // Input decode
  logic                    in_sign;
  logic [7:0]              in_exp;
  logic [MONTISSA_LEN-1:0] in_mant;
  logic signed [8:0]       in_e;
  logic [8:0]              in_e_mag;
  logic                    in_zero;
  logic                    in_sat;
  logic                    in_under;
  logic [W_LEN-1:0]        in_base;

  assign {in_sign, in_exp, in_mant} = ieee_val;
  assign in_e     = $signed({1'b0, in_exp}) - 9'sd127;
  assign in_e_mag = in_e[8] ? -in_e : in_e;
  assign in_zero  = (in_exp == 8'h00);
  assign in_sat   = (in_exp == 8'hFF) || (in_e >= E_OVF);
  assign in_under = (in_e < E_MIN);
  // Hidden one lands on the integer LSB position before any shift.
  assign in_base  = W_LEN'({1'b1, in_mant}) << FRA_LEN;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          left_d  = ~in_e[8];
          state_d = DONE;
          if (in_zero || in_under) begin
            w_d = '0;
          end else if (in_sat) begin
            w_d   = W_SAT;
            ovf_d = 1'b1;
          end else begin
`ifdef IEEE_TO_FIXED_FAST_SHIFT_EN
            w_d = in_e[8] ? (in_base >> in_e_mag) : (in_base << in_e_mag);
`else
            w_d   = in_base;
            cnt_d = in_e_mag[CNT_W-1:0];
            if (in_e_mag != 9'd0) begin
              state_d = SHIFT;
            end
`endif
          end
        end
      end

      SHIFT: begin
        w_d   = left_q ? (w_q << 1) : (w_q >> 1);
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  // Bits below the fraction LSB are dropped, giving truncation toward zero.
  assign o_integer  = w_q[W_LEN-1 -: INT_LEN];
  assign o_fraction = w_q[MONTISSA_LEN +: FRA_LEN];
  assign sign_flag  = sign_q;
  assign ovf        = ovf_q;
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);

endmodule

// File: tb/tb_ieee_to_fixed_converter.sv
// Randomized + directed bench for ieee_to_fixed_converter (16/16/23), scoreboard with decoupled monitor.
module tb_ieee_to_fixed_converter;

  logic        clk;
  logic        rst_n;
  logic [31:0] ieee_val;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] o_integer;
  logic [15:0] o_fraction;
  logic        sign_flag;
  logic        ovf;
  logic        out_valid;
  logic        out_ready;

  ieee_to_fixed_converter #(
    .INT_LEN(16),
    .FRA_LEN(16),
    .MONTISSA_LEN(23)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ieee_val(ieee_val),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .o_integer(o_integer),
    .o_fraction(o_fraction),
    .sign_flag(sign_flag),
    .ovf(ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [15:0] i;
    logic [15:0] f;
    logic        s;
    logic        o;
    int          lat;
    int          acc;
    logic [31:0] w;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic hold = 1'b0;
  logic seen = 1'b0;
  int   first_cyc;
  logic [33:0] cap;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Value = {1,mant} * 2^(e-23); scaled by 2^16 for the fixed-point grid, floored.
  function automatic exp_t model(input logic [31:0] w);
    exp_t   r;
    int     ex;
    int     e;
    longint m;
    longint v;
    ex    = int'(w[30:23]);
    e     = ex - 127;
    m     = longint'({1'b1, w[22:0]});
    r.s   = w[31];
    r.w   = w;
    r.o   = 1'b0;
    r.lat = 1;
    r.acc = 0;
    if (ex == 0) begin
      v = 0;
    end else if (ex == 255 || e >= 16) begin
      v   = 64'hFFFF_FFFF;
      r.o = 1'b1;
    end else begin
      if (e >= 7) v = m << (e - 7);
      else if (7 - e >= 63) v = 0;
      else v = m >> (7 - e);
      if (e >= -39) r.lat = 1 + ((e < 0) ? -e : e);
    end
`ifdef IEEE_TO_FIXED_FAST_SHIFT_EN
    r.lat = 1;
`endif
    r.i = v[31:16];
    r.f = v[15:0];
    return r;
  endfunction

  task automatic send(input logic [31:0] w);
    exp_t e;
    bit   ok;
    @(negedge clk);
    ieee_val = w;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout word=%08h in_ready stuck at 0", w);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e     = model(w);
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  // Consumer: random backpressure unless holding.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (!seen) begin
          seen      = 1'b1;
          first_cyc = cyc;
          cap       = {o_integer, o_fraction, sign_flag, ovf};
        end else begin
          chk("hold_stable", 64'({o_integer, o_fraction, sign_flag, ovf}), 64'(cap));
        end
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output int=%04h frac=%04h required=none", o_integer, o_fraction);
          end else begin
            e = sb.pop_front();
            chk($sformatf("int[%08h]", e.w), 64'(o_integer), 64'(e.i));
            chk($sformatf("frac[%08h]", e.w), 64'(o_fraction), 64'(e.f));
            chk($sformatf("sign[%08h]", e.w), 64'(sign_flag), 64'(e.s));
            chk($sformatf("ovf[%08h]", e.w), 64'(ovf), 64'(e.o));
            chk($sformatf("latency[%08h]", e.w), 64'(first_cyc - e.acc + 1), 64'(e.lat));
          end
          seen = 1'b0;
        end
      end
    end
  end

  logic [31:0] directed [14];

  initial begin : stim
    logic [31:0] w;
    bit drained;
    directed = '{32'h3F800000, 32'h40490FDB, 32'hC2C80000, 32'h47800000, 32'h7F800000,
                 32'h00000000, 32'h33800000, 32'h3F400000, 32'h477FFFFF, 32'h2C000000,
                 32'h2B800000, 32'h80000000, 32'hFF800000, 32'h7FC00000};
    ieee_val = '0;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'({o_integer, o_fraction, sign_flag, ovf}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    foreach (directed[k]) send(directed[k]);

    // Backpressure: result must stay put for 10+ cycles.
    hold = 1'b1;
    send(32'h40490FDB);
    repeat (14) @(negedge clk);
    hold = 1'b0;

    for (int n = 0; n < 250; n++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[30:23] = 8'($urandom_range(86, 145));
      send(w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset in the middle of an iterative shift drops the transaction.
    repeat (60) @(negedge clk);
    send(32'hC2C80000);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_outputs", 64'({o_integer, o_fraction, sign_flag, ovf}), 64'd0);
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);

    send(32'h3F400000);
    drained = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
